// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: tracks per-register busy bits and memory-unit
// occupancy, raises a combinational stall to Decode on any hazard, and emits
// a registered one-cycle issue pulse with unit select and destination.
module issue_scoreboard #(
   parameter int NREGS  = 32,
   parameter int MEMLAT = 3,
   parameter int CNTW   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_iss_addra,
   input  logic [4:0]       id_iss_addrb,
   input  logic [4:0]       id_iss_regdest,
   input  logic             id_iss_writereg,
   input  logic             id_iss_selimregb,
   input  logic             id_iss_selalushift,
   input  logic             id_iss_readmem,
   input  logic             id_iss_writemem,
   input  logic             wb_iss_writereg,
   input  logic [4:0]       wb_iss_regdest,
   output logic             iss_stall,
   output logic             iss_ex_issue,
   output logic [1:0]       iss_ex_unit,
   output logic [4:0]       iss_ex_regdest,
   output logic [NREGS-1:0] iss_busy,
   output logic [CNTW-1:0]  iss_stallcount
);

   typedef enum logic [1:0] {
      UNIT_ALU = 2'b00,
      UNIT_SHF = 2'b01,
      UNIT_MEM = 2'b10
   } unit_e;

   localparam logic [3:0] MEMLAT_L = 4'(MEMLAT);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] wb_mask;
   logic [NREGS-1:0] busy_eff;
   logic [3:0]       memcnt_q, memcnt_d;
   logic [CNTW-1:0]  stallcnt_q, stallcnt_d;
   logic             issue_q;
   unit_e            unit_q;
   logic [4:0]       regdest_q;
   unit_e            unit_c;
   logic             haz_rawa, haz_rawb, haz_waw, haz_struct;
   logic             fire;

   // Decode the target execute unit; memory access takes priority over shift.
   always_comb begin
      unit_c = UNIT_ALU;
      if (id_iss_readmem || id_iss_writemem)
         unit_c = UNIT_MEM;
      else if (id_iss_selalushift)
         unit_c = UNIT_SHF;
   end

   // Effective busy: a same-cycle writeback frees its register (write-through RF).
   always_comb begin
      wb_mask = '0;
      if (wb_iss_writereg)
         wb_mask[wb_iss_regdest] = 1'b1;
      busy_eff    = busy_q & ~wb_mask;
      busy_eff[0] = 1'b0;
   end

   // Hazard detection and stall/fire decision.
   always_comb begin
      haz_rawa   = busy_eff[id_iss_addra];
      haz_rawb   = (~id_iss_selimregb | id_iss_writemem) & busy_eff[id_iss_addrb];
      haz_waw    = id_iss_writereg & busy_eff[id_iss_regdest];
      haz_struct = (unit_c == UNIT_MEM) && (memcnt_q != 4'd0);
      iss_stall  = haz_rawa | haz_rawb | haz_waw | haz_struct;
      fire       = ~iss_stall;
   end

   // Next-state for busy vector, memory occupancy and stall counter.
   // Writeback clear is applied before the fire set so the set wins on a collision.
   always_comb begin
      busy_d = busy_q;
      if (wb_iss_writereg)
         busy_d[wb_iss_regdest] = 1'b0;
      if (fire && id_iss_writereg && (id_iss_regdest != 5'd0))
         busy_d[id_iss_regdest] = 1'b1;
      busy_d[0] = 1'b0;

      memcnt_d = memcnt_q;
      if (fire && (unit_c == UNIT_MEM))
         memcnt_d = MEMLAT_L;
      else if (memcnt_q != 4'd0)
         memcnt_d = memcnt_q - 4'd1;

      stallcnt_d = stallcnt_q;
      if (iss_stall && (stallcnt_q != '1))
         stallcnt_d = stallcnt_q + CNTW'(1);
   end

   // State registers with asynchronous reset; issue outputs hold when not firing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         memcnt_q   <= '0;
         stallcnt_q <= '0;
         issue_q    <= 1'b0;
         unit_q     <= UNIT_ALU;
         regdest_q  <= '0;
      end else begin
         busy_q     <= busy_d;
         memcnt_q   <= memcnt_d;
         stallcnt_q <= stallcnt_d;
         issue_q    <= fire;
         if (fire) begin
            unit_q    <= unit_c;
            regdest_q <= id_iss_regdest;
         end
      end
   end

   assign iss_ex_issue   = issue_q;
   assign iss_ex_unit    = unit_q;
   assign iss_ex_regdest = regdest_q;
   assign iss_busy       = busy_q;
   assign iss_stallcount = stallcnt_q;

endmodule
